// File: rtl/uart_px.sv
// uart_px: parametrised full-duplex UART with runtime divisor and per-bit taps
//   Optional parity: define UARTPX_PARITY_EN (even/odd selected by PARITY_ODD).
//   Ports: clk, rst_n (async active-low), div (clk cycles per bit, <4 -> 4),
//          rx / r_byte / received / frame_err / par_err / r_bit / r_bit_re (receive side),
//          tx / t_byte / transmit / t_ready / transmited / t_bit / t_bit_re (transmit side).
module uart_px #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              rx,
    output logic [DATA_W-1:0] r_byte,
    output logic              received,
    output logic              frame_err,
    output logic              par_err,
    output logic              tx,
    input  logic [DATA_W-1:0] t_byte,
    input  logic              transmit,
    output logic              t_ready,
    output logic              transmited,
    output logic              r_bit,
    output logic              r_bit_re,
    output logic              t_bit,
    output logic              t_bit_re
);
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UARTPX_PARITY_EN
        RX_PAR,
`endif
        RX_STOP, RX_BRK
    } rx_st_t;
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UARTPX_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_st_t;
    logic [DIV_W-1:0]  w_div;
    rx_st_t            r_rx_st;
    logic              r_rx_s1, r_rx_s2;
    logic [DIV_W-1:0]  r_rx_cnt, r_rx_d;
    logic [3:0]        r_rx_n;
    logic [DATA_W-1:0] r_rx_sh;
    tx_st_t            r_tx_st;
    logic [DIV_W-1:0]  r_tx_cnt, r_tx_d;
    logic [3:0]        r_tx_n;
    logic              r_tx_m;
    logic [DATA_W-1:0] r_tx_sh;
    assign w_div = (div < DIV_W'(4)) ? DIV_W'(4) : div;
`ifdef UARTPX_PARITY_EN
    logic r_rx_par, r_tx_p;
`else
    assign par_err = 1'b0;
`endif
    // Receiver: timers count down to 0; a frame is timed from the divisor latched at its start.
    // Start is detected on the synced level in IDLE so an edge that arrived during the
    // second half of a stop bit is still picked up once IDLE is re-entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_d    <= '0;
            r_rx_n    <= '0;
            r_rx_sh   <= '0;
            r_byte    <= '0;
            received  <= 1'b0;
            frame_err <= 1'b0;
            r_bit     <= 1'b0;
            r_bit_re  <= 1'b0;
`ifdef UARTPX_PARITY_EN
            r_rx_par  <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            received  <= 1'b0;
            frame_err <= 1'b0;
            r_bit_re  <= 1'b0;
            if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - 1'b1;
            case (r_rx_st)
                RX_IDLE: if (!r_rx_s2) begin
                    r_rx_st  <= RX_START;
                    r_rx_d   <= w_div;
                    r_rx_cnt <= (w_div >> 1) - 1'b1;
                end
                RX_START: if (r_rx_cnt == '0) begin
                    r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    r_rx_cnt <= r_rx_d - 1'b1;
                    r_rx_n   <= '0;
                end
                RX_DATA: if (r_rx_cnt == '0) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_W-1:1]};
                    r_bit    <= r_rx_s2;
                    r_bit_re <= 1'b1;
                    r_rx_cnt <= r_rx_d - 1'b1;
                    r_rx_n   <= r_rx_n + 1'b1;
`ifdef UARTPX_PARITY_EN
                    if (r_rx_n == 4'(DATA_W - 1)) r_rx_st <= RX_PAR;
`else
                    if (r_rx_n == 4'(DATA_W - 1)) r_rx_st <= RX_STOP;
`endif
                end
`ifdef UARTPX_PARITY_EN
                RX_PAR: if (r_rx_cnt == '0) begin
                    r_rx_par <= r_rx_s2;
                    r_rx_cnt <= r_rx_d - 1'b1;
                    r_rx_st  <= RX_STOP;
                end
`endif
                RX_STOP: if (r_rx_cnt == '0) begin
                    r_byte <= r_rx_sh;
                    if (r_rx_s2) begin
                        received <= 1'b1;
`ifdef UARTPX_PARITY_EN
                        par_err  <= ^r_rx_sh ^ r_rx_par ^ 1'(PARITY_ODD);
`endif
                        r_rx_st  <= RX_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        r_rx_st   <= RX_BRK;
                    end
                end
                RX_BRK: if (r_rx_s2) r_rx_st <= RX_IDLE;
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end
    // Transmitter: the last stop bit releases t_ready one cycle early (at count 1) so that
    // the final stop cycle is the IDLE cycle, letting a held transmit start with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            t_ready    <= 1'b1;
            transmited <= 1'b0;
            t_bit      <= 1'b0;
            t_bit_re   <= 1'b0;
            r_tx_st    <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_d     <= '0;
            r_tx_n     <= '0;
            r_tx_m     <= 1'b0;
            r_tx_sh    <= '0;
`ifdef UARTPX_PARITY_EN
            r_tx_p     <= 1'b0;
`endif
        end else begin
            transmited <= 1'b0;
            t_bit_re   <= 1'b0;
            if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 1'b1;
            case (r_tx_st)
                TX_IDLE: if (transmit) begin
                    r_tx_sh  <= t_byte;
`ifdef UARTPX_PARITY_EN
                    r_tx_p   <= ^t_byte ^ 1'(PARITY_ODD);
`endif
                    r_tx_d   <= w_div;
                    r_tx_cnt <= w_div - 1'b1;
                    t_ready  <= 1'b0;
                    tx       <= 1'b0;
                    r_tx_st  <= TX_START;
                end
                TX_START: if (r_tx_cnt == '0) begin
                    tx       <= r_tx_sh[0];
                    t_bit    <= r_tx_sh[0];
                    t_bit_re <= 1'b1;
                    r_tx_n   <= '0;
                    r_tx_cnt <= r_tx_d - 1'b1;
                    r_tx_st  <= TX_DATA;
                end
                TX_DATA: if (r_tx_cnt == '0) begin
                    r_tx_cnt <= r_tx_d - 1'b1;
                    if (r_tx_n == 4'(DATA_W - 1)) begin
`ifdef UARTPX_PARITY_EN
                        tx      <= r_tx_p;
                        r_tx_st <= TX_PAR;
`else
                        tx      <= 1'b1;
                        r_tx_m  <= 1'b0;
                        r_tx_st <= TX_STOP;
`endif
                    end else begin
                        r_tx_sh  <= r_tx_sh >> 1;
                        tx       <= r_tx_sh[1];
                        t_bit    <= r_tx_sh[1];
                        t_bit_re <= 1'b1;
                        r_tx_n   <= r_tx_n + 1'b1;
                    end
                end
`ifdef UARTPX_PARITY_EN
                TX_PAR: if (r_tx_cnt == '0) begin
                    tx       <= 1'b1;
                    r_tx_m   <= 1'b0;
                    r_tx_cnt <= r_tx_d - 1'b1;
                    r_tx_st  <= TX_STOP;
                end
`endif
                TX_STOP: begin
                    if (r_tx_m == 1'(STOP_BITS - 1)) begin
                        if (r_tx_cnt == DIV_W'(1)) begin
                            transmited <= 1'b1;
                            t_ready    <= 1'b1;
                            r_tx_st    <= TX_IDLE;
                        end
                    end else if (r_tx_cnt == '0) begin
                        r_tx_m   <= 1'b1;
                        r_tx_cnt <= r_tx_d - 1'b1;
                    end
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_px.sv
// tb_uart_px: randomized self-checking bench for uart_px against a bit-level frame model
module tb_uart_px;
    localparam int DW = 8;
`ifdef UARTPX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] div = 16'd8;
    logic rx = 1'b1;
    logic [7:0] r_byte, t_byte = 8'h00;
    logic received, frame_err, par_err, tx, transmit = 1'b0;
    logic t_ready, transmited, r_bit, r_bit_re, t_bit, t_bit_re;
    int n_chk = 0, n_fail = 0;
    int n_rcv = 0, n_ferr = 0, n_rre = 0, n_tre = 0;
    logic [7:0] rcv_byte = 8'h00, rbits = 8'h00, tbits = 8'h00;
    logic rcv_perr = 1'b0;

    uart_px dut (
        .clk(clk), .rst_n(rst_n), .div(div), .rx(rx), .r_byte(r_byte),
        .received(received), .frame_err(frame_err), .par_err(par_err), .tx(tx),
        .t_byte(t_byte), .transmit(transmit), .t_ready(t_ready), .transmited(transmited),
        .r_bit(r_bit), .r_bit_re(r_bit_re), .t_bit(t_bit), .t_bit_re(t_bit_re)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (received) begin n_rcv++; rcv_byte = r_byte; rcv_perr = par_err; end
        if (frame_err) n_ferr++;
        if (r_bit_re) begin n_rre++; rbits = {r_bit, rbits[7:1]}; end
        if (t_bit_re) begin n_tre++; tbits = {t_bit, tbits[7:1]}; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected tx level in cycle c (1-based after acceptance): bit index (c-1)/d of
    // {start=0, data LSB first, [parity], stop=1}.
    task automatic tx_frame(input logic [7:0] b, input int d, input bit keep);
        int errs, de, n0, idx;
        logic e;
        logic [7:0] bb;
        bb = b;
        errs = 0;
        de = (d < 4) ? 4 : d;
        n0 = n_tre;
        t_byte = b;
        div = 16'(d);
        transmit = 1'b1;
        for (int c = 1; c <= (2 + DW + PB) * de; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) transmit = 1'b0;
            if (c == 2) div = 16'($urandom_range(0, 40));
            idx = (c - 1) / de;
            e = (idx == 0) ? 1'b0 : (idx <= DW) ? bb[idx-1] : (PB == 1 && idx == DW + 1) ? ^bb : 1'b1;
            if (tx !== e) errs++;
        end
        check("tx_wave", errs, 0);
        check("transmited", transmited, 1);
        check("t_ready_end", t_ready, 1);
        check("t_bit_re_cnt", n_tre - n0, DW);
        check("t_bit_vals", tbits, b);
    endtask

    task automatic rx_frame(input logic [7:0] b, input int d, input logic stopv, input logic pflip);
        int r0, f0, b0, de;
        logic [7:0] bb;
        bb = b;
        r0 = n_rcv; f0 = n_ferr; b0 = n_rre;
        de = (d < 4) ? 4 : d;
        div = 16'(d);
        for (int k = 0; k < 2 + DW + PB; k++) begin
            rx = (k == 0) ? 1'b0 : (k <= DW) ? bb[k-1] : (PB == 1 && k == DW + 1) ? (^bb ^ pflip) : stopv;
            if (k == 2) div = 16'($urandom_range(0, 40));
            repeat (de) @(negedge clk);
        end
        if (!stopv) begin
            repeat (40 - de) @(negedge clk);
            rx = 1'b1;
            repeat (2 * de) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (stopv) begin
            check("rx_received", n_rcv - r0, 1);
            check("rx_byte", rcv_byte, b);
            check("rx_ferr_none", n_ferr - f0, 0);
            check("rx_bit_vals", rbits, b);
            check("rx_bit_re_cnt", n_rre - b0, DW);
`ifdef UARTPX_PARITY_EN
            check("rx_par_err", rcv_perr, pflip);
`endif
        end else begin
            check("ferr_pulse", n_ferr - f0, 1);
            check("ferr_no_rcv", n_rcv - r0, 0);
            check("ferr_r_byte", r_byte, b);
        end
    endtask

    initial begin
        int r0, f0, b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_t_ready", t_ready, 1);
        check("rst_r_byte", r_byte, 0);
        check("rst_pulses", {received, frame_err, par_err, transmited, r_bit_re, t_bit_re}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_frame(8'hA5, 8, 1'b1, 1'b0);
        tx_frame(8'h3C, 8, 1'b1);
        tx_frame(8'h3C, 8, 1'b0);
        repeat (5) @(negedge clk);
        r0 = n_rcv; f0 = n_ferr; b0 = n_rre;
        div = 16'd8;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rcv", n_rcv - r0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_bits", n_rre - b0, 0);
        rx_frame(8'h96, 8, 1'b1, 1'b0);
        rx_frame(8'h55, 8, 1'b0, 1'b0);
        rx_frame(8'($urandom), 8, 1'b1, 1'b0);
`ifdef UARTPX_PARITY_EN
        rx_frame(8'h01, 8, 1'b1, 1'b1);
        rx_frame(8'h01, 8, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 6; i++) begin
            rx_frame(8'($urandom), int'($urandom_range(4, 20)), 1'b1, 1'b0);
            tx_frame(8'($urandom), int'($urandom_range(4, 20)), 1'b0);
        end
        tx_frame(8'($urandom), 2, 1'b0);
        rx_frame(8'($urandom), 1, 1'b1, 1'b0);
        t_byte = 8'hC3;
        div = 16'd8;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (4 * 8 + 3) @(negedge clk);
        check("pre_rst_busy", t_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_t_ready", t_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_frame(8'h5A, 8, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
